// File: rtl/call_stack_pkg.sv
// Shared definitions for the return-address stack.
// Holds the PC width, the default depth and the {push,pop} operation decode.
package call_stack_pkg;

  localparam int PC_W      = 12;
  localparam int RAS_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic p, input logic q);
    return stack_op_e'({p, q});
  endfunction

endpackage

// File: rtl/call_stack_regfile.sv
// DEPTH x ADDR_W register array for the call stack.
// Provides one synchronous write port, one combinational read port and a synchronous clear.
module stack_regfile
  import call_stack_pkg::*;
#(
  parameter int ADDR_W = PC_W,
  parameter int DEPTH  = RAS_DEPTH,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack for the pipelined processor.
// Decodes stall-qualified push/pop, tracks the stack pointer and keeps sticky debug flags.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int ADDR_W = PC_W,
  parameter int DEPTH  = RAS_DEPTH,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_pc,
  output logic [ADDR_W-1:0] top_pc,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  logic [PTR_W:0]    sp_q, sp_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [PTR_W:0]    sp_minus1;
  logic [PTR_W:0]    sp_plus1;
  logic              stack_empty;
  logic              stack_full;
  logic              we;
  logic [PTR_W-1:0]  waddr;
  logic [ADDR_W-1:0] rdata;
  stack_op_e         op;

  assign sp_minus1   = sp_q - (PTR_W+1)'(1);
  assign sp_plus1    = sp_q + (PTR_W+1)'(1);
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == (PTR_W+1)'(DEPTH));
  assign op          = decode_op(push & ~stall, pop & ~stall);

  always_comb begin
    sp_d        = sp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    we          = 1'b0;
    waddr       = sp_q[PTR_W-1:0];
    case (op)
      OP_PUSH: begin
        if (stack_full) begin
          overflow_d = 1'b1;
        end else begin
          we    = 1'b1;
          waddr = sp_q[PTR_W-1:0];
          sp_d  = sp_plus1;
        end
      end
      OP_POP: begin
        if (stack_empty) begin
          underflow_d = 1'b1;
        end else begin
          sp_d = sp_minus1;
        end
      end
      OP_REPL: begin
        // A replace on an empty stack degrades to a plain push but is still flagged.
        if (stack_empty) begin
          we          = 1'b1;
          waddr       = '0;
          sp_d        = (PTR_W+1)'(1);
          underflow_d = 1'b1;
        end else begin
          we    = 1'b1;
          waddr = sp_minus1[PTR_W-1:0];
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  stack_regfile #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (push_pc),
    .raddr (sp_minus1[PTR_W-1:0]),
    .rdata (rdata)
  );

  assign top_pc    = stack_empty ? '0 : rdata;
  assign count     = sp_q;
  assign empty     = stack_empty;
  assign full      = stack_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
